// File: rtl/isqrt_rr_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined isqrt among N_REQ requesters.
// A {valid, id} tag pipeline tracks each operation so the result returns to its requester.
module isqrt_rr_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned ISQRT_LATENCY = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     req_vld,
  input  logic [32*N_REQ-1:0]                  req_x,
  output logic [N_REQ-1:0]                     req_rdy,
  output logic [N_REQ-1:0]                     rsp_vld,
  output logic [15:0]                          rsp_y,
  output logic                                 isqrt_x_vld,
  output logic [31:0]                          isqrt_x,
  input  logic                                 isqrt_y_vld,
  input  logic [15:0]                          isqrt_y,
  output logic [$clog2(ISQRT_LATENCY+2)-1:0]   inflight,
  output logic                                 err
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned CW  = $clog2(ISQRT_LATENCY + 2);

  logic [IDW-1:0]             ptr;
  logic [IDW-1:0]             cand;
  logic [IDW-1:0]             gnt_id;
  logic                       gnt;

  logic [ISQRT_LATENCY-1:0]   tag_vld;
  logic [IDW-1:0]             tag_id [ISQRT_LATENCY];
  logic                       last_vld;
  logic [IDW-1:0]             last_id;

  // Scan from ptr upward, wrapping; the first valid requester wins.
  always_comb begin
    gnt    = 1'b0;
    gnt_id = '0;
    cand   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDW'((32'(ptr) + k) % N_REQ);
      if (!gnt && req_vld[cand]) begin
        gnt    = 1'b1;
        gnt_id = cand;
      end
    end
  end

  always_comb begin
    req_rdy     = '0;
    isqrt_x_vld = gnt;
    isqrt_x     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt && gnt_id == IDW'(k)) begin
        req_rdy[k] = 1'b1;
        isqrt_x    = req_x[32*k +: 32];
      end
    end
  end

  assign last_vld = tag_vld[ISQRT_LATENCY-1];
  assign last_id  = tag_id[ISQRT_LATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      for (int unsigned s = 0; s < ISQRT_LATENCY; s++) tag_id[s] <= '0;
    end else begin
      tag_vld[0] <= gnt;
      tag_id[0]  <= gnt_id;
      for (int unsigned s = 1; s < ISQRT_LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (gnt) begin
      ptr <= (32'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_vld <= '0;
      rsp_y   <= '0;
    end else begin
      rsp_vld <= '0;
      if (isqrt_y_vld && last_vld) begin
        for (int unsigned k = 0; k < N_REQ; k++) rsp_vld[k] <= (last_id == IDW'(k));
        rsp_y <= isqrt_y;
      end
    end
  end

  // A result without a tag, or a tag without a result, is dropped and flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (isqrt_y_vld != last_vld) begin
      err <= 1'b1;
    end
  end

  // Every valid tag leaving the pipeline retires one operation, returned or dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
    end else begin
      case ({gnt, last_vld})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
